// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//   Program-counter owner and single-outstanding instruction fetcher for the
//   single-cycle MIPS core. Requests one word at a time over a req/ack port,
//   holds it for the control unit, then steps the PC using the branch/jump
//   decisions the datapath returns for the held instruction.
//
// Handshake: IMemReq is high for every cycle the fetcher waits for a word and
//   IMemAddr is stable for that whole time. A word is accepted on the rising
//   edge where IMemReq=1 and IMemAck=1; IMemAck at any other time is ignored.
//
// Ports
//   clk, reset          : rising-edge clock, asynchronous active-low reset
//   Stall               : 1 = keep the held instruction
//   BranchEQ/BranchNE/Zero/BranchOffset/Jump/JumpTarget
//                       : next-PC controls for the held instruction
//   IMemReq/IMemAddr    : fetch request and byte address
//   IMemAck/IMemData    : memory data-valid and instruction word
//   Instruction/OP      : held word and its opcode (NOP_OP when invalid)
//   PC/PCPlus4          : address of held/pending instruction and PC + 4
//   InstValid           : Instruction/OP carry a fetched word
//   FetchFault          : sticky memory-timeout flag
//   DbgState            : current FSM state (0=REQ, 1=HOLD, 2=FAULT)
// -----------------------------------------------------------------------------
module instruction_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0040_0000,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter logic [5:0]  NOP_OP      = 6'h3F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic        BranchEQ,
  input  logic        BranchNE,
  input  logic        Zero,
  input  logic [31:0] BranchOffset,
  input  logic        Jump,
  input  logic [25:0] JumpTarget,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemAck,
  input  logic [31:0] IMemData,
  output logic [31:0] Instruction,
  output logic [5:0]  OP,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        InstValid,
  output logic        FetchFault,
  output logic [1:0]  DbgState
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_HOLD  = 2'd1,
    S_FAULT = 2'd2
  } state_e;

  // Counter value seen on the last ack-less edge allowed before faulting.
  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        fault_q, fault_d;

  logic [31:0] pc_plus4;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic        branch_taken;
  logic [31:0] next_pc;

  // Next-PC selection: jump beats branch beats sequential.
  always_comb begin
    pc_plus4      = pc_q + 32'd4;
    branch_target = pc_plus4 + (BranchOffset << 2);
    jump_target   = {pc_plus4[31:28], JumpTarget, 2'b00};
    branch_taken  = (BranchEQ & Zero) | (BranchNE & ~Zero);
    if (Jump)              next_pc = jump_target;
    else if (branch_taken) next_pc = branch_target;
    else                   next_pc = pc_plus4;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    case (state_q)
      S_REQ: begin
        // An ack on the final allowed edge still completes the fetch.
        if (IMemAck) begin
          instr_d = IMemData;
          valid_d = 1'b1;
          cnt_d   = 8'd0;
          state_d = S_HOLD;
        end else if (cnt_q == TIMEOUT_LAST) begin
          cnt_d   = cnt_q + 8'd1;
          valid_d = 1'b0;
          fault_d = 1'b1;
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_HOLD: begin
        if (!Stall) begin
          pc_d    = next_pc;
          valid_d = 1'b0;
          cnt_d   = 8'd0;
          state_d = S_REQ;
        end
      end
      S_FAULT: begin
        valid_d = 1'b0;
        fault_d = 1'b1;
      end
      default: begin
        valid_d = 1'b0;
        cnt_d   = 8'd0;
        state_d = S_REQ;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      valid_q <= 1'b0;
      cnt_q   <= 8'd0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  assign IMemReq     = (state_q == S_REQ);
  assign IMemAddr    = pc_q;
  assign PC          = pc_q;
  assign PCPlus4     = pc_plus4;
  assign Instruction = instr_q;
  assign InstValid   = valid_q;
  assign OP          = valid_q ? instr_q[31:26] : NOP_OP;
  assign FetchFault  = fault_q;
  assign DbgState    = state_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
//   Directed bench for instruction_fetch. The stimulus thread pushes every
//   expected fetch address and fetched word; a negedge monitor pops and
//   compares whenever a new request or a newly valid instruction appears.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

  logic        clk;
  logic        reset;
  logic        Stall;
  logic        BranchEQ;
  logic        BranchNE;
  logic        Zero;
  logic [31:0] BranchOffset;
  logic        Jump;
  logic [25:0] JumpTarget;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemAck;
  logic [31:0] IMemData;
  logic [31:0] Instruction;
  logic [5:0]  OP;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        InstValid;
  logic        FetchFault;
  logic [1:0]  DbgState;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_ins_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  instruction_fetch dut (
    .clk          (clk),
    .reset        (reset),
    .Stall        (Stall),
    .BranchEQ     (BranchEQ),
    .BranchNE     (BranchNE),
    .Zero         (Zero),
    .BranchOffset (BranchOffset),
    .Jump         (Jump),
    .JumpTarget   (JumpTarget),
    .IMemReq      (IMemReq),
    .IMemAddr     (IMemAddr),
    .IMemAck      (IMemAck),
    .IMemData     (IMemData),
    .Instruction  (Instruction),
    .OP           (OP),
    .PC           (PC),
    .PCPlus4      (PCPlus4),
    .InstValid    (InstValid),
    .FetchFault   (FetchFault),
    .DbgState     (DbgState)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic scramble_side();
    BranchEQ     = 1'($urandom_range(0, 1));
    BranchNE     = 1'($urandom_range(0, 1));
    Zero         = 1'($urandom_range(0, 1));
    Jump         = 1'($urandom_range(0, 1));
    BranchOffset = $urandom();
    JumpTarget   = 26'($urandom());
  endtask

  // Leave S_HOLD with the given next-PC controls; exp_addr is the next fetch.
  task automatic release_hold(input logic j, input logic [25:0] jt, input logic beq,
                              input logic bne, input logic z, input logic [31:0] off,
                              input logic [31:0] exp_addr);
    exp_addr_q.push_back(exp_addr);
    Jump = j; JumpTarget = jt; BranchEQ = beq; BranchNE = bne; Zero = z; BranchOffset = off;
    Stall = 1'b0;
    @(posedge clk); #1;
    Stall = 1'b1;
    scramble_side();
  endtask

  // Memory driver: answer the current request after 'waits' ack-less cycles.
  task automatic fetch(input logic [31:0] data, input int waits);
    int guard;
    logic [31:0] a0;
    guard = 0;
    while (!IMemReq && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!IMemReq) begin
      check("req_seen", {31'd0, IMemReq}, 32'd1);
      return;
    end
    a0 = IMemAddr;
    repeat (waits) begin
      @(posedge clk); #1;
      check("addr_stable", IMemAddr, a0);
      check("req_held", {31'd0, IMemReq}, 32'd1);
    end
    IMemAck = 1'b1;
    IMemData = data;
    exp_ins_q.push_back(data);
    @(posedge clk); #1;
    IMemAck = 1'b0;
    IMemData = $urandom();
    check("valid_after_ack", {31'd0, InstValid}, 32'd1);
    check("req_low_in_hold", {31'd0, IMemReq}, 32'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin : monitor
    logic req_prev, val_prev;
    logic [31:0] e;
    req_prev = 1'b0;
    val_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        req_prev = 1'b0;
        val_prev = 1'b0;
      end else begin
        if (IMemReq && !req_prev) begin
          if (exp_addr_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_req: got addr %h expected no request", IMemAddr);
          end else begin
            e = exp_addr_q.pop_front();
            check("req_addr", IMemAddr, e);
          end
        end
        if (InstValid && !val_prev) begin
          if (exp_ins_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_valid: got instr %h expected none", Instruction);
          end else begin
            e = exp_ins_q.pop_front();
            check("instr_word", Instruction, e);
            check("instr_op", {26'd0, OP}, {26'd0, e[31:26]});
          end
        end
        req_prev = IMemReq;
        val_prev = InstValid;
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: got no completion expected finish before 100000ns");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0; Stall = 1'b1; IMemAck = 1'b0; IMemData = 32'd0;
    scramble_side();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, InstValid}, 32'd0);
    check("rst_fault", {31'd0, FetchFault}, 32'd0);
    check("rst_pc", PC, 32'h0040_0000);
    check("rst_instr", Instruction, 32'd0);
    check("rst_op", {26'd0, OP}, 32'h3F);
    check("rst_req", {31'd0, IMemReq}, 32'd1);

    // First fetch, zero wait.
    exp_addr_q.push_back(32'h0040_0000);
    reset = 1'b1;
    fetch(32'h2008_0005, 0);
    check("first_op", {26'd0, OP}, 32'h08);
    check("first_pc", PC, 32'h0040_0000);
    check("first_pc4", PCPlus4, 32'h0040_0004);

    // Sequential, then jump to 0x0040_0010.
    release_hold(1'b0, 26'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0040_0004);
    fetch(32'h0000_0020, 1);
    release_hold(1'b1, 26'h010_0004, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0040_0010);
    fetch(32'h1000_0003, 0);
    check("jump_pc", PC, 32'h0040_0010);

    // beq taken backwards, then back to 0x0040_0010.
    release_hold(1'b0, 26'd0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0040_0004);
    fetch(32'h0800_0000, 0);
    release_hold(1'b1, 26'h010_0004, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0040_0010);
    fetch(32'h1000_FFFC, 0);
    // beq not taken.
    release_hold(1'b0, 26'd0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0040_0014);
    fetch(32'h1400_0001, 0);
    release_hold(1'b1, 26'h010_0004, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0040_0010);
    fetch(32'h1400_0002, 0);
    // bne with Zero=1: not taken.
    release_hold(1'b0, 26'd0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0040_0014);
    fetch(32'h8C00_0000, 0);
    release_hold(1'b1, 26'h010_0004, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0040_0010);
    fetch(32'hAC00_0000, 0);
    // Jump beats an asserted branch.
    release_hold(1'b1, 26'h010_0000, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0040_0000);
    fetch(32'h0C00_0010, 0);
    check("jprio_op", {26'd0, OP}, 32'h03);

    // beq and bne both set with Zero=0: taken, offset 3 words.
    release_hold(1'b0, 26'd0, 1'b1, 1'b1, 1'b0, 32'h0000_0003, 32'h0040_0010);
    fetch(32'h2401_0007, 0);
    // Branch to the top of the address space (carry discarded).
    release_hold(1'b0, 26'd0, 1'b1, 1'b0, 1'b1, 32'h3FEF_FFFA, 32'hFFFF_FFFC);
    fetch(32'h3C01_1234, 0);
    check("top_pc", PC, 32'hFFFF_FFFC);
    check("wrap_pc4", PCPlus4, 32'h0000_0000);
    release_hold(1'b0, 26'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0000_0000);
    fetch(32'h3421_5678, 0);

    // Stall for three cycles.
    repeat (3) begin
      @(posedge clk); #1;
      check("stall_instr", Instruction, 32'h3421_5678);
      check("stall_pc", PC, 32'h0000_0000);
      check("stall_op", {26'd0, OP}, 32'h0D);
      check("stall_req", {31'd0, IMemReq}, 32'd0);
    end
    release_hold(1'b0, 26'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0000_0004);
    check("req_after_stall", {31'd0, IMemReq}, 32'd1);
    fetch(32'h0000_0000, 3);

    // Memory never answers.
    release_hold(1'b0, 26'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0000_0008);
    repeat (14) begin @(posedge clk); #1; end
    check("pre_timeout_fault", {31'd0, FetchFault}, 32'd0);
    check("pre_timeout_req", {31'd0, IMemReq}, 32'd1);
    @(posedge clk); #1;
    check("timeout_fault", {31'd0, FetchFault}, 32'd1);
    check("timeout_req", {31'd0, IMemReq}, 32'd0);
    check("timeout_op", {26'd0, OP}, 32'h3F);
    check("timeout_state", {30'd0, DbgState}, 32'd2);
    IMemAck = 1'b1; IMemData = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    IMemAck = 1'b0;
    check("late_ack_fault", {31'd0, FetchFault}, 32'd1);
    check("late_ack_valid", {31'd0, InstValid}, 32'd0);

    // Reset clears the fault.
    reset = 1'b0;
    #1;
    check("rst2_fault", {31'd0, FetchFault}, 32'd0);
    check("rst2_addr", IMemAddr, 32'h0040_0000);
    @(posedge clk); #1;
    exp_addr_q.push_back(32'h0040_0000);
    reset = 1'b1;
    check("rst2_req", {31'd0, IMemReq}, 32'd1);
    fetch(32'h8C22_0004, 0);
    check("lw_op", {26'd0, OP}, 32'h23);

    // Reset mid-hold drops InstValid at once.
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check("rst_hold_valid", {31'd0, InstValid}, 32'd0);
    check("rst_hold_op", {26'd0, OP}, 32'h3F);
    check("rst_hold_instr", Instruction, 32'd0);
    @(posedge clk); #1;
    exp_addr_q.push_back(32'h0040_0000);
    reset = 1'b1;
    fetch(32'hAC22_0008, 0);

    // Reset mid-request; an ack during reset is ignored.
    release_hold(1'b0, 26'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0040_0004);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check("rst_req_pc", PC, 32'h0040_0000);
    check("rst_req_valid", {31'd0, InstValid}, 32'd0);
    IMemAck = 1'b1; IMemData = 32'h1234_5678;
    @(posedge clk); #1;
    check("ack_in_rst_valid", {31'd0, InstValid}, 32'd0);
    check("ack_in_rst_instr", Instruction, 32'd0);
    IMemAck = 1'b0;
    exp_addr_q.push_back(32'h0040_0000);
    reset = 1'b1;
    fetch(32'h1000_FFFF, 0);
    check("final_pc4", PCPlus4, 32'h0040_0004);

    repeat (3) @(posedge clk);
    #1;
    check("addr_q_drained", exp_addr_q.size(), 32'd0);
    check("ins_q_drained", exp_ins_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Upstream neighbour of the opcode-decoding control unit in the single-cycle MIPS core.
- Owns the program counter and fetches one instruction at a time over a req/ack instruction-memory port.
- Holds the fetched word and presents its opcode field to the control unit.
- Computes the next PC from branch/jump decisions returned by the datapath; detects memory timeouts.

Parameters:
RESET_PC, 32'h0040_0000, PC value after reset (word aligned)
MEM_TIMEOUT, 15, max S_REQ cycles without ack before fault (1..255)
NOP_OP, 6'h3F, opcode driven on OP when no valid instruction (control decodes it to all-zero controls)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
Stall  in  1  1 = hold current instruction in S_HOLD
BranchEQ  in  1  beq decoded for held instruction
BranchNE  in  1  bne decoded for held instruction
Zero  in  1  ALU zero flag for held instruction
BranchOffset  in  32  sign-extended immediate of held instruction
Jump  in  1  jump decoded for held instruction
JumpTarget  in  26  instr_index field of held instruction
IMemReq  out  1  fetch request
IMemAddr  out  32  fetch byte address
IMemAck  in  1  memory data valid this cycle
IMemData  in  32  instruction word
Instruction  out  32  held instruction word
OP  out  6  opcode to control unit
PC  out  32  address of held/pending instruction
PCPlus4  out  32  PC + 4
InstValid  out  1  Instruction/OP valid
FetchFault  out  1  sticky memory-timeout flag

Behaviour:
- Reset (reset=0, async): state=S_REQ, PC=RESET_PC, Instruction=0, InstValid=0, wait counter=0, FetchFault=0. Takes effect immediately, including mid-request or mid-hold. IMemReq/IMemAddr follow state combinationally.
- Outputs are combinational from registers:
  - IMemReq = (state==S_REQ); IMemAddr = PC.
  - PCPlus4 = PC + 32'd4, modulo 2^32 (wraps to 0).
  - OP = InstValid ? Instruction[31:26] : NOP_OP.
- States:
  - S_REQ: request asserted; IMemAddr stable until ack.
    - Edge with IMemAck=1: Instruction<=IMemData, InstValid<=1, counter<=0, go S_HOLD. A zero-wait ack (first S_REQ cycle) is legal.
    - Edge with IMemAck=0: counter+1. If the counter already equals MEM_TIMEOUT-1 (i.e. the MEM_TIMEOUT-th ack-less edge), go S_FAULT.
    - Ack on that final edge wins over the timeout.
  - S_HOLD: IMemReq=0. Instruction, PC and InstValid are stable. IMemAck is ignored.
    - Stall=1: remain.
    - Stall=0: PC<=NextPC, InstValid<=0, counter<=0, go S_REQ.
  - S_FAULT: FetchFault=1, IMemReq=0, InstValid=0. Leaves only via reset.
- NextPC priority:
  1. Jump=1: {PCPlus4[31:28], JumpTarget, 2'b00}.
  2. Else taken = (BranchEQ&Zero)|(BranchNE&~Zero): PCPlus4 + (BranchOffset<<2), 32-bit wraparound, carry discarded. BranchEQ and BranchNE both 1 counts as taken.
  3. Else PCPlus4.
- Branch/jump inputs are sampled only on the S_HOLD->S_REQ edge and ignored in all other states.
- Throughput: minimum 2 cycles per instruction (1 S_REQ + 1 S_HOLD). Latency from ack edge to InstValid=1 is 0 cycles after that edge.
- Exactly one fetch is outstanding at a time. A late ack arriving after reset or in S_HOLD/S_FAULT is ignored.

Test Plan:
- Release reset; memory acks the first request with 32'h2008_0005 -> IMemAddr=0x0040_0000, IMemReq 1 cycle. Then InstValid=1, OP=0x08, PCPlus4=0x0040_0004. Stall=0 -> next IMemAddr=0x0040_0004.
- Held PC=0x0040_0010, BranchEQ=1, Zero=1, BranchOffset=0xFFFF_FFFC -> next IMemAddr=0x0040_0004. Same inputs with Zero=0 -> 0x0040_0014.
- Held PC=0x0040_0010, BranchNE=1, Zero=1 -> 0x0040_0014 (not taken). With Jump=1, JumpTarget=26'h010_0000 also asserted -> 0x0040_0000 (jump priority).
- Stall=1 for 3 cycles in S_HOLD -> Instruction, PC and OP unchanged, IMemReq=0. Stall=0 -> request issued next cycle. Ack with 3 wait cycles -> IMemAddr constant for 4 cycles.
- Memory never acks -> after 15 S_REQ cycles FetchFault=1, IMemReq=0, OP=0x3F. Assert reset -> FetchFault=0, IMemAddr=0x0040_0000, IMemReq=1 after release.
- Reset pulse asserted while in S_REQ with ack pending -> InstValid=0 immediately, PC=RESET_PC. An ack arriving during reset is ignored.
